// File: rtl/mmu_array.sv
`default_nettype none
// ============================================================================
// Module      : mmu_array
// Description : 2x2 output-stationary systolic MAC array. Weights (a) flow
//               left to right, inputs (b) flow top to bottom, one register
//               per hop. Each cell keeps a signed ACC_W-bit accumulator,
//               presents an 8-bit saturated result and a sticky
//               out-of-range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_array #(
  parameter int ACC_W = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] a_data0,
  input  logic [7:0] a_data1,
  input  logic [7:0] b_data0,
  input  logic [7:0] b_data1,
  output logic [7:0] c00,
  output logic [7:0] c01,
  output logic [7:0] c10,
  output logic [7:0] c11,
  output logic [3:0] sat_flags
);

  // Saturation bounds of the 8-bit signed result, at accumulator width.
  localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-128);

  // Forwarding registers: only the hops that feed a downstream cell exist.
  logic signed [7:0]       a00_q;   // PE00 a -> PE01
  logic signed [7:0]       b00_q;   // PE00 b -> PE10
  logic signed [7:0]       a10_q;   // PE10 a -> PE11
  logic signed [7:0]       b01_q;   // PE01 b -> PE11

  // Cell index: 0 = PE00, 1 = PE01, 2 = PE10, 3 = PE11.
  logic signed [7:0]       w_a    [4];
  logic signed [7:0]       w_b    [4];
  logic signed [15:0]      w_prod [4];
  logic signed [ACC_W-1:0] acc_q  [4];
  logic signed [ACC_W-1:0] acc_d  [4];
  logic [3:0]              flags_q;
  logic [3:0]              flags_d;
  logic [7:0]              w_c    [4];

  // Route the operand pair seen by each cell this cycle.
  always_comb begin
    w_a[0] = $signed(a_data0);
    w_b[0] = $signed(b_data0);
    w_a[1] = a00_q;
    w_b[1] = $signed(b_data1);
    w_a[2] = $signed(a_data1);
    w_b[2] = b00_q;
    w_a[3] = a10_q;
    w_b[3] = b01_q;
  end

  // Next accumulator value and sticky flag update from the full 16-bit product.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_prod[i]  = w_a[i] * w_b[i];
      acc_d[i]   = acc_q[i] + {{(ACC_W-16){w_prod[i][15]}}, w_prod[i]};
      flags_d[i] = flags_q[i] | ((acc_d[i] > C_SAT_MAX) || (acc_d[i] < C_SAT_MIN));
    end
  end

  // State update; reset and clear both wipe partial sums and in-flight operands.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
      end
      flags_q <= 4'b0000;
      a00_q   <= '0;
      b00_q   <= '0;
      a10_q   <= '0;
      b01_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= acc_d[i];
      end
      flags_q <= flags_d;
      a00_q   <= w_a[0];
      b00_q   <= w_b[0];
      a10_q   <= w_a[2];
      b01_q   <= w_b[1];
    end
  end

  // Saturate each registered accumulator to the signed 8-bit result range.
  for (genvar g = 0; g < 4; g++) begin : g_sat
    assign w_c[g] = (acc_q[g] > C_SAT_MAX) ? 8'h7F :
                    (acc_q[g] < C_SAT_MIN) ? 8'h80 :
                    acc_q[g][7:0];
  end

  assign c00       = w_c[0];
  assign c01       = w_c[1];
  assign c10       = w_c[2];
  assign c11       = w_c[3];
  assign sat_flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_array
// Description : Self-checking bench for mmu_array. Directed scenarios plus
//               randomized matrix products compared against a matrix-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_array;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [7:0] a_data0;
  logic [7:0] a_data1;
  logic [7:0] b_data0;
  logic [7:0] b_data1;
  logic [7:0] c00;
  logic [7:0] c01;
  logic [7:0] c10;
  logic [7:0] c11;
  logic [3:0] sat_flags;

  int checks = 0;
  int errors = 0;

  // Reference model: per-cell running sum of the matrix product and sticky flags.
  int         m_acc [4];
  logic [3:0] m_flag;

  mmu_array #(.ACC_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .a_data0   (a_data0),
    .a_data1   (a_data1),
    .b_data0   (b_data0),
    .b_data1   (b_data1),
    .c00       (c00),
    .c01       (c01),
    .c10       (c10),
    .c11       (c11),
    .sat_flags (sat_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs(input int i);
    case (i)
      0:       return c00;
      1:       return c01;
      2:       return c10;
      default: return c11;
    endcase
  endfunction

  function automatic logic [7:0] sat8(input int v);
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic int rnd8();
    logic signed [7:0] t;
    t = 8'($urandom);
    return int'(t);
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    m_flag = 4'b0000;
  endfunction

  // C += W x X, each cell summing its k=0 term before its k=1 term.
  function automatic void m_matmul(input int w0, w1, w2, w3, x0, x1, x2, x3);
    int mw [2][2];
    int mx [2][2];
    mw = '{'{w0, w1}, '{w2, w3}};
    mx = '{'{x0, x1}, '{x2, x3}};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++) begin
          m_acc[i*2+j] += mw[i][k] * mx[k][j];
          if (m_acc[i*2+j] > 127 || m_acc[i*2+j] < -128) m_flag[i*2+j] = 1'b1;
        end
  endfunction

  // One clock of stimulus; outputs are sampled 1ns after the edge.
  task automatic drive(input logic [7:0] a0, a1, b0, b1, input logic clr);
    a_data0 = a0;
    a_data1 = a1;
    b_data0 = b0;
    b_data1 = b1;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  // Feeder schedule for one 2x2 product (four cycles, last one all zero).
  task automatic sched(input int w0, w1, w2, w3, x0, x1, x2, x3);
    drive(8'(w0), 8'h00, 8'(x0), 8'h00, 1'b0);
    drive(8'(w1), 8'(w2), 8'(x2), 8'(x1), 1'b0);
    drive(8'h00, 8'(w3), 8'h00, 8'(x3), 1'b0);
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    m_matmul(w0, w1, w2, w3, x0, x1, x2, x3);
  endtask

  task automatic do_clear();
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    clear = 1'b0;
    m_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 3; n++)
      drive(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset c[%0d]: got %h expected 00", i, obs(i));
      end
    end
    checks++;
    if (sat_flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset flags: got %b expected 0000", sat_flags);
    end
    rst = 1'b0;
    m_clear();
  endtask

  task automatic test_latency();
    logic [7:0] exp_c [4];
    do_clear();
    drive(8'd3, 8'd0, 8'd5, 8'd0, 1'b0);
    exp_c = '{8'd15, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL latency edge0 c[%0d]: got %0d expected %0d", i, obs(i), exp_c[i]);
      end
    end
    drive(8'd0, 8'd2, 8'd0, 8'd7, 1'b0);
    exp_c = '{8'd15, 8'd21, 8'd10, 8'd0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL latency edge1 c[%0d]: got %0d expected %0d", i, obs(i), exp_c[i]);
      end
    end
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    exp_c = '{8'd15, 8'd21, 8'd10, 8'd14};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL latency edge2 c[%0d]: got %0d expected %0d", i, obs(i), exp_c[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_c [4];
    do_clear();
    sched(1, 2, 3, 4, 5, 6, 7, 8);
    exp_c = '{8'd19, 8'd22, 8'd43, 8'd50};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL basic c[%0d]: got %0d expected %0d", i, obs(i), exp_c[i]);
      end
    end
    checks++;
    if (sat_flags !== 4'b0000) begin
      errors++;
      $display("FAIL basic flags: got %b expected 0000", sat_flags);
    end
  endtask

  task automatic test_signed();
    logic [7:0] exp_c [4];
    do_clear();
    sched(-3, 4, 0, 0, 5, 0, -2, 0);
    exp_c = '{8'hE9, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL signed c[%0d]: got %h expected %h", i, obs(i), exp_c[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_clear();
    sched(127, 127, 127, 127, 127, 127, 127, 127);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h7F) begin
        errors++;
        $display("FAIL sat_pos c[%0d]: got %h expected 7f", i, obs(i));
      end
    end
    checks++;
    if (sat_flags !== 4'b1111) begin
      errors++;
      $display("FAIL sat_pos flags: got %b expected 1111", sat_flags);
    end
    do_clear();
    checks++;
    if (sat_flags !== 4'b0000) begin
      errors++;
      $display("FAIL sat_clear flags: got %b expected 0000", sat_flags);
    end
    sched(-128, -128, -128, -128, 127, 127, 127, 127);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h80) begin
        errors++;
        $display("FAIL sat_neg c[%0d]: got %h expected 80", i, obs(i));
      end
    end
    checks++;
    if (sat_flags !== 4'b1111) begin
      errors++;
      $display("FAIL sat_neg flags: got %b expected 1111", sat_flags);
    end
  endtask

  // Partial sum 16129 overflows, final sum -127 is back in range: flag stays.
  task automatic test_sticky();
    do_clear();
    sched(127, -128, 0, 0, 127, 0, 127, 0);
    checks++;
    if (c00 !== 8'h81) begin
      errors++;
      $display("FAIL sticky c00: got %h expected 81", c00);
    end
    checks++;
    if (sat_flags !== 4'b0001) begin
      errors++;
      $display("FAIL sticky flags: got %b expected 0001", sat_flags);
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    drive(8'd1, 8'd0, 8'd5, 8'd0, 1'b0);
    drive(8'd2, 8'd3, 8'd7, 8'd6, 1'b0);
    drive(8'd0, 8'd4, 8'd0, 8'd8, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h00) begin
        errors++;
        $display("FAIL clear_mid edge2 c[%0d]: got %h expected 00", i, obs(i));
      end
    end
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h00) begin
        errors++;
        $display("FAIL clear_mid edge3 c[%0d]: got %h expected 00", i, obs(i));
      end
    end
    checks++;
    if (sat_flags !== 4'b0000) begin
      errors++;
      $display("FAIL clear_mid flags: got %b expected 0000", sat_flags);
    end
    m_clear();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_c [4];
    do_clear();
    drive(8'd1, 8'd0, 8'd5, 8'd0, 1'b0);
    rst = 1'b1;
    drive(8'd2, 8'd3, 8'd7, 8'd6, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid c[%0d]: got %h expected 00", i, obs(i));
      end
    end
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid drain c[%0d]: got %h expected 00", i, obs(i));
      end
    end
    m_clear();
    sched(1, 2, 3, 4, 5, 6, 7, 8);
    exp_c = '{8'd19, 8'd22, 8'd43, 8'd50};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL reset_mid rerun c[%0d]: got %0d expected %0d", i, obs(i), exp_c[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_c [4];
    do_clear();
    sched(1, 2, 3, 4, 5, 6, 7, 8);
    sched(1, 2, 3, 4, 5, 6, 7, 8);
    exp_c = '{8'd38, 8'd44, 8'd86, 8'd100};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs(i) !== exp_c[i]) begin
        errors++;
        $display("FAIL back_to_back c[%0d]: got %0d expected %0d", i, obs(i), exp_c[i]);
      end
    end
    checks++;
    if (sat_flags !== 4'b0000) begin
      errors++;
      $display("FAIL back_to_back flags: got %b expected 0000", sat_flags);
    end
  endtask

  // Random matrices, 1..3 products accumulated per run, checked against the model.
  task automatic test_random();
    int w [4];
    int x [4];
    int nprod;
    for (int it = 0; it < 25; it++) begin
      do_clear();
      nprod = $urandom_range(1, 3);
      for (int p = 0; p < nprod; p++) begin
        for (int k = 0; k < 4; k++) begin
          w[k] = (it < 5) ? int'($urandom_range(0, 6)) - 3 : rnd8();
          x[k] = (it < 5) ? int'($urandom_range(0, 6)) - 3 : rnd8();
        end
        sched(w[0], w[1], w[2], w[3], x[0], x[1], x[2], x[3]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs(i) !== sat8(m_acc[i])) begin
          errors++;
          $display("FAIL random it%0d c[%0d]: got %h expected %h (acc %0d)",
                   it, i, obs(i), sat8(m_acc[i]), m_acc[i]);
        end
      end
      checks++;
      if (sat_flags !== m_flag) begin
        errors++;
        $display("FAIL random it%0d flags: got %b expected %b", it, sat_flags, m_flag);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    clear   = 1'b0;
    a_data0 = 8'h00;
    a_data1 = 8'h00;
    b_data0 = 8'h00;
    b_data1 = 8'h00;
    m_clear();
    #2;
    test_reset();
    test_latency();
    test_basic();
    test_signed();
    test_saturation();
    test_sticky();
    test_clear_mid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmu_array.md
MMU_ARRAY -- requirements
Module: mmu_array

Interface
REQ-001 The block SHALL have parameter ACC_W, default 18, giving the signed accumulator width per cell; legal values are 17 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous clear of all accumulators, pipeline registers and flags.
REQ-005 The block SHALL have ports a_data0 and a_data1, input, 8 bits each, signed two's complement: weight streams entering row 0 and row 1 from the left.
REQ-006 The block SHALL have ports b_data0 and b_data1, input, 8 bits each, signed two's complement: input streams entering column 0 and column 1 from the top.
REQ-007 The block SHALL have ports c00, c01, c10 and c11, output, 8 bits each, signed: the saturated result of cell (row, column).
REQ-008 The block SHALL have port sat_flags, output, 4 bits: sticky saturation flags, with bit0=c00, bit1=c01, bit2=c10, bit3=c11.

Function
REQ-009 The block SHALL be a 2x2 output-stationary systolic array of four processing elements (PEs), PE(i,j), each holding one ACC_W-bit signed accumulator acc_ij.
REQ-010 The a operand SHALL flow left to right and the b operand SHALL flow top to bottom, with one register stage per hop.
- PE00: a = a_data0, b = b_data0.
- PE01: a = PE00 registered a, b = b_data1.
- PE10: a = a_data1, b = PE00 registered b.
- PE11: a = PE10 registered a, b = PE01 registered b.
REQ-011 On each rising edge with rst=0 and clear=0, every PE SHALL perform acc <= acc + sext(a*b) and SHALL register its a and b operands for forwarding.
- The product is a full 16-bit signed product.
- Zero operands produce no change to the accumulator.
REQ-012 The latency SHALL be as follows:
- An operand pair present at PE00 in cycle k SHALL be reflected in acc00 after edge k.
- It SHALL reach PE01 and PE10 for the MAC at edge k+1.
- It SHALL reach PE11 for the MAC at edge k+2.
REQ-013 With the feeder schedule below, the final accumulators SHALL equal C = W x X, where W = [[w0,w1],[w2,w3]] and X = [[x0,x1],[x2,x3]], valid after edge 3.
- Cycle 0: a0=w0, b0=x0.
- Cycle 1: a0=w1, a1=w2, b0=x2, b1=x1.
- Cycle 2: a1=w3, b1=x3.
- Cycle 3 onward: all inputs zero.
REQ-014 Each c_ij SHALL be combinational from acc_ij:
- 127 if acc_ij > 127.
- -128 (0x80) if acc_ij < -128.
- Otherwise acc_ij[7:0].
REQ-015 A sat_flags bit SHALL set at any edge where the updated accumulator lies outside [-128,127], and SHALL remain set until clear or rst, even if the accumulator returns in range.
REQ-016 The accumulator SHALL NOT wrap within a single 2-term matrix product, since the worst case of +/-32768 (magnitude) fits in 17 bits. Further accumulation without clear wraps modulo 2^ACC_W, and this is not required to be detected.
REQ-017 When clear=1, the next edge SHALL zero all accumulators, forwarding registers and sat_flags, and SHALL discard any operands presented in that cycle (clear has priority over MAC).
REQ-018 When clear=0 and no reset is applied, accumulators SHALL retain and continue summing across consecutive products.
REQ-019 The block SHALL contain no combinational path from a_data or b_data to c_ij; c_ij SHALL depend only on registered state.

Reset
REQ-020 When rst=1 at a rising edge, all accumulators, forwarding registers and sat_flags SHALL become 0, so that c00..c11 = 0x00 and sat_flags = 4'b0000.
REQ-021 rst SHALL take priority over clear and data; asserting rst mid-accumulation SHALL discard all partial sums and in-flight operands.
REQ-022 The first MAC after rst deasserts SHALL use the operands presented in that cycle.

Verification
REQ-023 Basic product: W=[1,2,3,4], X=[5,6,7,8] per the REQ-013 schedule -> after edge 3: c00=19, c01=22, c10=43, c11=50, sat_flags=0000.
REQ-024 Signed product: w0=-3 (0xFD), w1=4, x0=5, x2=-2, all others 0 -> c00=-23 (0xE9), c01=0, c10=0, c11=0.
REQ-025 Saturation:
- All weights and inputs set to 127 -> acc=32258, all c=127, sat_flags=1111.
- Then clear, then W=-128 and X=127 everywhere -> all c=0x80, sat_flags=1111.
REQ-026 Clear mid-operation: run the REQ-023 stimulus with clear=1 during cycle 2 -> all c=0 after edge 2; cycle 3 zeros keep c=0; the w3/x3 pair is dropped.
REQ-027 Reset mid-operation: assert rst in cycle 1 of the REQ-023 stimulus -> all outputs 0; a subsequent full schedule yields 19/22/43/50.
REQ-028 Accumulate without clear: run the REQ-023 schedule twice back-to-back -> c00=38, c01=44, c10=86, c11=100, sat_flags=0000.
